// File: rtl/cam_pkg.sv
// cam_pkg: shared types and constants for the camera capture path.
//   cam_state_t : frame sequencer states
//   CAM_*       : default sensor geometry (VGA, YUYV)
//   FLAG_*      : SOP/EOP flag encoding carried in FIFO word bits [25:24]
package cam_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    SYNC    = 3'd2,
    CAPTURE = 3'd3,
    DROP    = 3'd4
  } cam_state_t;

  localparam int CAM_WIDTH           = 640;
  localparam int CAM_HEIGHT          = 480;
  localparam int CAM_BYTES_PER_PIXEL = 2;

  localparam logic [1:0] FLAG_SOP = 2'b01;
  localparam logic [1:0] FLAG_EOP = 2'b10;

endpackage

// File: rtl/cam_edge_detect.sv
// cam_edge_detect: registers one input and flags its edges.
//   pixel_clock, reset : clock, synchronous active-high reset
//   din                : signal to watch
//   rise / fall        : high in the cycle din differs from its registered copy
module cam_edge_detect (
  input  logic pixel_clock,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic din_q;

  always_ff @(posedge pixel_clock) begin
    if (reset) din_q <= 1'b0;
    else       din_q <= din;
  end

  assign rise = din & ~din_q;
  assign fall = ~din & din_q;

endmodule

// File: rtl/camera_frame_sequencer.sv
// camera_frame_sequencer: arms, gates and checks camera frame capture.
// Only whole, vsync-aligned frames are let through capture_en; each frame is
// graded at its closing vsync edge.
//   in : pixel_clock, reset (sync, active-high), vsync, href, fifo_full,
//        cmd_start, cmd_continuous, cmd_stop
//   out: capture_en, busy, frame_done, frame_error, overflow (sticky),
//        line_count, frame_count
// Build option: define CAMSEQ_LINE_CHECK_EN to also check every line's byte
// count against WIDTH*BYTES_PER_PIXEL; otherwise only the line count is checked.
module camera_frame_sequencer
  import cam_pkg::*;
#(
  parameter int WIDTH           = CAM_WIDTH,
  parameter int HEIGHT          = CAM_HEIGHT,
  parameter int BYTES_PER_PIXEL = CAM_BYTES_PER_PIXEL,
  parameter int FCNT_W          = 16
) (
  input  logic                        pixel_clock,
  input  logic                        reset,
  input  logic                        vsync,
  input  logic                        href,
  input  logic                        fifo_full,
  input  logic                        cmd_start,
  input  logic                        cmd_continuous,
  input  logic                        cmd_stop,
  output logic                        capture_en,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        frame_error,
  output logic                        overflow,
  output logic [$clog2(HEIGHT+1)-1:0] line_count,
  output logic [FCNT_W-1:0]           frame_count
);

  localparam int LW = $clog2(HEIGHT+1);
  localparam int BW = $clog2(WIDTH*BYTES_PER_PIXEL+1);
  localparam logic [LW-1:0] LAST_LINE  = LW'(HEIGHT);
  localparam logic [BW-1:0] LINE_BYTES = BW'(WIDTH*BYTES_PER_PIXEL);

  cam_state_t state;
  logic       cont;
  logic       err;
  logic       vsync_rise, vsync_fall, href_rise, href_fall;

  cam_edge_detect u_vsync_edge (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .din         (vsync),
    .rise        (vsync_rise),
    .fall        (vsync_fall)
  );

  cam_edge_detect u_href_edge (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .din         (href),
    .rise        (href_rise),
    .fall        (href_fall)
  );

  logic unused_href_rise;
  assign unused_href_rise = href_rise;

`ifdef CAMSEQ_LINE_CHECK_EN
  logic [BW-1:0] byte_cnt;

  // Counts href-high cycles; holds the finished line's length in the cycle
  // the href falling edge is seen, then restarts.
  always_ff @(posedge pixel_clock) begin
    if (reset)                              byte_cnt <= '0;
    else if (state == SYNC && vsync_fall)   byte_cnt <= '0;
    else if (href_fall)                     byte_cnt <= '0;
    else if (href && byte_cnt != '1)        byte_cnt <= byte_cnt + 1'b1;
  end
`else
  logic [BW-1:0] unused_line_bytes;
  assign unused_line_bytes = LINE_BYTES;
`endif

  // Line bookkeeping is computed ahead of the register so a line that ends in
  // the same cycle as the closing vsync edge still counts toward the grade.
  logic          line_fin, ovf_now, good_frame, stay_on;
  logic [LW-1:0] line_nxt;
  logic          err_nxt;

  always_comb begin
    line_fin = (state == CAPTURE) && href_fall;
    ovf_now  = (state == CAPTURE) && fifo_full && href;
    line_nxt = line_count;
    err_nxt  = err;
    if (line_fin) begin
      if (line_count == LAST_LINE) err_nxt  = 1'b1;
      else                         line_nxt = line_count + 1'b1;
`ifdef CAMSEQ_LINE_CHECK_EN
      if (byte_cnt != LINE_BYTES)  err_nxt  = 1'b1;
`endif
    end
    good_frame = (line_nxt == LAST_LINE) && !err_nxt && !ovf_now;
    // a stop arriving with the closing edge still ends continuous mode
    stay_on    = cont && !cmd_stop;
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      state       <= IDLE;
      cont        <= 1'b0;
      err         <= 1'b0;
      capture_en  <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      overflow    <= 1'b0;
      line_count  <= '0;
      frame_count <= '0;
    end else begin
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      if (ovf_now) overflow <= 1'b1;
      case (state)
        IDLE: if (cmd_start && !cmd_stop) begin
          state    <= ARM;
          busy     <= 1'b1;
          cont     <= cmd_continuous;
          overflow <= 1'b0;
        end
        ARM: begin
          if (cmd_stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (vsync_rise) begin
            state <= SYNC;
          end
        end
        SYNC: begin
          if (cmd_stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (vsync_fall) begin
            state      <= CAPTURE;
            capture_en <= 1'b1;
            line_count <= '0;
            err        <= 1'b0;
          end
        end
        CAPTURE: begin
          line_count <= line_nxt;
          err        <= err_nxt;
          if (cmd_stop) cont <= 1'b0;
          if (vsync_rise) begin
            if (good_frame) begin
              frame_done  <= 1'b1;
              frame_count <= frame_count + 1'b1;
            end else begin
              frame_error <= 1'b1;
            end
            state      <= stay_on ? SYNC : IDLE;
            busy       <= stay_on;
            capture_en <= 1'b0;
          end else if (ovf_now) begin
            state      <= DROP;
            capture_en <= 1'b0;
          end
        end
        DROP: begin
          if (cmd_stop) cont <= 1'b0;
          if (vsync_rise) begin
            frame_error <= 1'b1;
            state       <= stay_on ? SYNC : IDLE;
            busy        <= stay_on;
          end
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          capture_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_camera_frame_sequencer.sv
module tb_camera_frame_sequencer;

  logic       pixel_clock = 1'b0;
  logic       reset = 1'b1;
  logic       vsync = 1'b0, href = 1'b0, fifo_full = 1'b0;
  logic       cmd_start = 1'b0, cmd_continuous = 1'b0, cmd_stop = 1'b0;
  logic       capture_en, busy, frame_done, frame_error, overflow;
  logic [1:0] line_count;
  logic [1:0] frame_count;

  int nchk = 0, nerr = 0;
  int done_pulses = 0, err_pulses = 0;
  int exp_fc = 0;

  camera_frame_sequencer #(
    .WIDTH(4), .HEIGHT(3), .BYTES_PER_PIXEL(2), .FCNT_W(2)
  ) dut (
    .pixel_clock    (pixel_clock),
    .reset          (reset),
    .vsync          (vsync),
    .href           (href),
    .fifo_full      (fifo_full),
    .cmd_start      (cmd_start),
    .cmd_continuous (cmd_continuous),
    .cmd_stop       (cmd_stop),
    .capture_en     (capture_en),
    .busy           (busy),
    .frame_done     (frame_done),
    .frame_error    (frame_error),
    .overflow       (overflow),
    .line_count     (line_count),
    .frame_count    (frame_count)
  );

  always #5 pixel_clock = ~pixel_clock;

  always @(negedge pixel_clock) begin
    if (frame_done)  done_pulses++;
    if (frame_error) err_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pixel_clock);
    #1;
  endtask

  task automatic start(input logic c);
    cmd_start = 1'b1; cmd_continuous = c;
    tick();
    cmd_start = 1'b0; cmd_continuous = 1'b0;
  endtask

  // vsync pulse from ARM/SYNC into CAPTURE
  task automatic open_frame();
    vsync = 1'b1; tick(); tick();
    vsync = 1'b0; tick();
  endtask

  task automatic line(input int n);
    href = 1'b1;
    repeat (n) tick();
    href = 1'b0;
    tick(); tick();
  endtask

  task automatic close_frame();
    vsync = 1'b1; tick();
  endtask

  task automatic settle();
    tick(); vsync = 1'b0; tick();
  endtask

  initial begin
    // reset state
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_cap", capture_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_lc", line_count, 0);
    chk("rst_fc", frame_count, 0);

    // single good frame, with a fifo_full while href is low in the middle
    start(1'b0);
    chk("s1_busy", busy, 1);
    vsync = 1'b1; tick(); tick();
    chk("s1_sync_cap", capture_en, 0);
    vsync = 1'b0; tick();
    chk("s1_cap_on", capture_en, 1);
    line(8);
    fifo_full = 1'b1; tick(); fifo_full = 1'b0;
    chk("s1_full_idle_href", overflow, 0);
    chk("s1_full_idle_cap", capture_en, 1);
    line(8); line(8);
    chk("s1_lc", line_count, 3);
    close_frame(); exp_fc = 1;
    chk("s1_done", frame_done, 1);
    chk("s1_cap_off", capture_en, 0);
    chk("s1_busy_off", busy, 0);
    chk("s1_fc", frame_count, 1);
    tick();
    chk("s1_done_1cyc", frame_done, 0);
    vsync = 1'b0; tick();

    // continuous: three frames, stop during the third
    start(1'b1);
    open_frame();
    line(8); line(8); line(8);
    close_frame(); exp_fc = 2;
    chk("c1_done", frame_done, 1);
    chk("c1_busy", busy, 1);
    chk("c1_fc", frame_count, 2);
    tick(); vsync = 1'b0; tick();
    chk("c2_cap", capture_en, 1);
    line(8); line(8); line(8);
    close_frame(); exp_fc = 3;
    chk("c2_fc", frame_count, 3);
    tick(); vsync = 1'b0; tick();
    line(8);
    cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
    chk("c3_after_stop_cap", capture_en, 1);
    line(8); line(8);
    close_frame(); exp_fc = 0;  // 4 wraps in a 2-bit counter
    chk("c3_done", frame_done, 1);
    chk("c3_fc_wrap", frame_count, 0);
    chk("c3_busy", busy, 0);
    settle();
    chk("c3_idle_cap", capture_en, 0);

    // short line
    start(1'b0);
    open_frame();
    line(8); line(7); line(8);
    close_frame();
`ifdef CAMSEQ_LINE_CHECK_EN
    chk("short_err", frame_error, 1);
    chk("short_done", frame_done, 0);
`else
    exp_fc = exp_fc + 1;
    chk("short_err", frame_error, 0);
    chk("short_done", frame_done, 1);
`endif
    chk("short_fc", frame_count, exp_fc & 3);
    settle();

    // too few lines
    start(1'b0);
    open_frame();
    line(8); line(8);
    close_frame();
    chk("geo2_err", frame_error, 1);
    chk("geo2_lc", line_count, 2);
    settle();

    // too many lines
    start(1'b0);
    open_frame();
    line(8); line(8); line(8); line(8);
    close_frame();
    chk("geo4_err", frame_error, 1);
    chk("geo4_lc", line_count, 3);
    chk("geo4_fc", frame_count, exp_fc & 3);
    settle();

    // overflow on line 2
    start(1'b0);
    open_frame();
    line(8);
    href = 1'b1; tick(); tick(); tick();
    fifo_full = 1'b1; tick(); fifo_full = 1'b0;
    chk("ovf_cap", capture_en, 0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_busy", busy, 1);
    tick(); tick(); tick(); tick();
    href = 1'b0; tick(); tick();
    line(8);
    close_frame();
    chk("ovf_err", frame_error, 1);
    settle();
    chk("ovf_sticky", overflow, 1);
    start(1'b0);
    chk("ovf_clr", overflow, 0);
    cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
    chk("arm_stop_busy", busy, 0);

    // reset during capture
    start(1'b0);
    open_frame();
    line(8);
    chk("mid_lc", line_count, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_rst_all",
        {capture_en, busy, frame_done, frame_error, overflow, line_count, frame_count}, 0);
    tick();

    // start and stop together in IDLE
    cmd_start = 1'b1; cmd_stop = 1'b1; tick();
    cmd_start = 1'b0; cmd_stop = 1'b0;
    chk("startstop_busy", busy, 0);
    tick();
    chk("startstop_busy2", busy, 0);

`ifdef CAMSEQ_LINE_CHECK_EN
    chk("done_pulses", done_pulses, 4);
    chk("err_pulses", err_pulses, 4);
`else
    chk("done_pulses", done_pulses, 5);
    chk("err_pulses", err_pulses, 3);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/camera_frame_sequencer.md
# camera_frame_sequencer

Pixel-clock-domain controller that arms, gates and checks camera frame capture for the YUYV-to-RGB streaming datapath. It watches `vsync`/`href` and the clock-crossing FIFO's write-side full flag. It drives `capture_en`, which gates datapath FIFO writes, so that only whole, frame-aligned images enter the FIFO. It also reports per-frame completion, geometry errors and overflow to the control side.

## Interface
- `WIDTH`, 640, active pixels per line
- `HEIGHT`, 480, active lines per frame
- `BYTES_PER_PIXEL`, 2, camera bytes per pixel (YUYV)
- `FCNT_W`, 16, width of the captured-frame counter
- `pixel_clock`  in  1  clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `vsync`  in  1  camera frame sync, high = vertical blanking
- `href`  in  1  camera line valid, one byte per cycle while high
- `fifo_full`  in  1  clock-crossing FIFO write-side full
- `cmd_start`  in  1  one-cycle pulse, already synchronised to `pixel_clock`
- `cmd_continuous`  in  1  level; sampled together with `cmd_start`
- `cmd_stop`  in  1  one-cycle pulse, already synchronised
- `capture_en`  out  1  datapath may write the FIFO
- `busy`  out  1  sequencer is not in IDLE
- `frame_done`  out  1  one-cycle pulse: good frame completed
- `frame_error`  out  1  one-cycle pulse: frame ended bad
- `overflow`  out  1  sticky; FIFO was full during capture
- `line_count`  out  clog2(HEIGHT+1)  lines completed in the current frame
- `frame_count`  out  FCNT_W  good frames since reset; wraps

## Operation
- States:
  - **IDLE:** no capture. `cmd_start` moves to ARM and latches `cont <= cmd_continuous`.
  - **ARM:** waiting for the first vsync. A vsync rising edge moves to SYNC.
  - **SYNC:** in vsync. A vsync falling edge moves to CAPTURE and clears `line_count`, the byte counter and `err`.
  - **CAPTURE:** capturing the frame. `fifo_full` while `href` is high sets `overflow` and moves to DROP. A vsync rising edge ends the frame.
  - **DROP:** discarding the rest of the frame. A vsync rising edge pulses `frame_error`.
- Edge detection uses registered copies `vsync_q`/`href_q`. Rising edge = `vsync & ~vsync_q`.
- Byte counter (clog2(WIDTH*BYTES_PER_PIXEL+1) bits) counts cycles with `href` high. It saturates at its maximum and clears on each href falling edge.
- On each href falling edge in CAPTURE:
  - `line_count` increments, saturating at HEIGHT.
  - `err` is set if the line had the wrong length (see Configuration).
  - `err` is also set if the line would be line HEIGHT+1.
- End of frame (vsync rising edge in CAPTURE):
  - Good frame: `line_count==HEIGHT` and `err` clear. Pulse `frame_done` and increment `frame_count`.
  - Otherwise pulse `frame_error`.
- Next state after end of frame (CAPTURE or DROP): SYNC if `cont` is set, else IDLE.
- `cmd_stop`:
  - In ARM or SYNC: go to IDLE immediately.
  - In CAPTURE or DROP: clear `cont`, so the current frame finishes and the sequencer then goes to IDLE.
- Simultaneous `cmd_start` and `cmd_stop`: stop wins. `cmd_start` outside IDLE is ignored.
- `overflow` is cleared only by reset or by an accepted `cmd_start`.
- Reset mid-operation:
  - State returns to IDLE.
  - All outputs return to 0: `capture_en`, `busy`, `frame_done`, `frame_error`, `overflow`, `line_count`, `frame_count`.
  - Internal registers `cont`, `err`, the byte counter, `vsync_q` and `href_q` return to 0.

## Timing
- Every output is registered; none is combinational from inputs.
- `capture_en` is high exactly while the state is CAPTURE.
  - It rises on the clock edge after the cycle in which the vsync falling edge is seen.
  - It falls on the clock edge after the cycle in which `fifo_full` with `href` is seen, or a vsync rising edge is seen.
- Latency from the `vsync`/`href` pin to a decision is 1 cycle.
- `frame_done`/`frame_error` are asserted for exactly one cycle, one cycle after the vsync rising edge.
- `fifo_full` while `href` is low does not cause overflow.
- `frame_count` wraps from 2^FCNT_W−1 to 0 silently.

## Configuration
- `CAMSEQ_LINE_CHECK_EN` defined:
  - Each href falling edge in CAPTURE compares the byte count with `WIDTH*BYTES_PER_PIXEL`.
  - A mismatch sets `err`.
- Undefined:
  - There is no byte counter.
  - Only the line count, including the line HEIGHT+1 check, is validated.

## Structure
- Shared package `cam_pkg`:
  - The state enum: IDLE, ARM, SYNC, CAPTURE, DROP.
  - Default WIDTH/HEIGHT/BYTES_PER_PIXEL constants.
  - The 2-bit flag encoding for FIFO word bits [25:24]: SOP=01, EOP=10.
- One sub-module, `cam_edge_detect`:
  - Registers one input.
  - Outputs one-cycle rise and fall pulses.
  - Instantiated for `vsync` and for `href`.

## Test plan
All scenarios use WIDTH=4, HEIGHT=3, BYTES_PER_PIXEL=2.
- Single good frame: `cmd_start` with `cmd_continuous=0`, then a vsync pulse, then 3 lines of 8 bytes, then a vsync rising edge → `frame_done` for 1 cycle, `frame_count`=1, `capture_en` high only between the vsync falling edge+1 and the rising edge+1, state returns to IDLE.
- Continuous mode: 3 frames of 3×8 bytes → 3 `frame_done` pulses, `frame_count`=3, `busy` stays high. `cmd_stop` mid-frame-3 → frame 3 still completes, then IDLE.
- Short line (`CAMSEQ_LINE_CHECK_EN` defined): line 2 has 7 bytes → `frame_error` pulse and `frame_count` unchanged. With the macro undefined, the same stimulus → `frame_done`.
- Geometry: 2 lines, then vsync → `frame_error`. 4 lines, then vsync → `frame_error`, `line_count`=3.
- Overflow: `fifo_full` high for 1 cycle during line 2 with `href` high → next cycle `capture_en`=0 and `overflow`=1. At vsync → `frame_error`. The next `cmd_start` clears `overflow`.
- Reset during CAPTURE after 1 line → next cycle every output is 0. Simultaneous `cmd_start` and `cmd_stop` in IDLE → stays in IDLE.
